// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU issue controller and its request queue.
package fpu_issue_pkg;

    localparam int DATA_W          = 32;
    localparam int OPCODE_W        = 6;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } issue_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]   op_a;
        logic [DATA_W-1:0]   op_b;
        logic [OPCODE_W-1:0] opcode;
    } fpu_req_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Request queue: circular buffer with wrapping pointers and an occupancy count.
module fpu_req_fifo
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(fpu_req_t)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Queues FPU requests and issues them one at a time, holding each result
// until downstream accepts it; flags a sticky error if the FPU never answers.
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [DATA_W-1:0]   req_op_a_i,
    input  logic [DATA_W-1:0]   req_op_b_i,
    input  logic [OPCODE_W-1:0] req_opcode_i,
    output logic                fpu_enable_o,
    output logic [DATA_W-1:0]   fpu_op_a_o,
    output logic [DATA_W-1:0]   fpu_op_b_o,
    output logic [OPCODE_W-1:0] fpu_opcode_o,
    input  logic [DATA_W-1:0]   fpu_result_i,
    input  logic                fpu_valid_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_result_o,
    input  logic                flush_i,
    output logic                err_o
);

    localparam int TIMEOUT = 4 * LATENCY;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    issue_state_e      state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    fpu_req_t          fpu_req_q, fpu_req_d;

    fpu_req_t          head;
    fpu_req_t          req_in;
    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;

    assign req_in      = '{op_a: req_op_a_i, op_b: req_op_b_i, opcode: req_opcode_i};
    assign req_ready_o = !q_full;
    assign q_push      = req_valid_i && !q_full && !flush_i;

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fpu_req_t))
    ) u_req_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .flush_i (flush_i),
        .push_i  (q_push),
        .wdata_i (req_in),
        .pop_i   (q_pop),
        .rdata_o (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Flush overrides every state; fpu_valid_i only matters while waiting.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        rsp_result_d = rsp_result_q;
        fpu_req_d    = fpu_req_q;
        q_pop        = 1'b0;
        if (flush_i) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!q_empty) begin
                        q_pop     = 1'b1;
                        fpu_req_d = head;
                        state_d   = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (fpu_valid_i) begin
                        rsp_result_d = fpu_result_i;
                        state_d      = ST_HOLD;
                    end else if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            rsp_result_q <= '0;
            fpu_req_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            rsp_result_q <= rsp_result_d;
            fpu_req_q    <= fpu_req_d;
        end
    end

    assign fpu_enable_o = (state_q == ST_ISSUE);
    assign rsp_valid_o  = (state_q == ST_HOLD);
    assign rsp_result_o = rsp_result_q;
    assign err_o        = err_q;
    assign fpu_op_a_o   = fpu_req_q.op_a;
    assign fpu_op_b_o   = fpu_req_q.op_b;
    assign fpu_opcode_o = fpu_req_q.opcode;

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, request queue entries; power of two, at least 2.
REQ-002 Parameter LATENCY, default 2, cycles from fpu_enable_o to expected fpu_valid_i.
REQ-003 Clk  in  1  clock; all state is updated on the rising edge.
REQ-004 Reset  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  1  upstream request present.
REQ-006 req_ready_o  out  1  queue can accept a request.
REQ-007 req_op_a_i / req_op_b_i  in  32 each  request operands.
REQ-008 req_opcode_i  in  6  FPU opcode.
REQ-009 fpu_enable_o  out  1  one-cycle issue strobe to the FPU.
REQ-010 fpu_op_a_o / fpu_op_b_o  out  32 each  operands presented to the FPU.
REQ-011 fpu_opcode_o  out  6  opcode presented to the FPU.
REQ-012 fpu_result_i  in  32  FPU result.
REQ-013 fpu_valid_i  in  1  FPU result valid.
REQ-014 rsp_valid_o  out  1  response available.
REQ-015 rsp_ready_i  in  1  downstream accepts the response.
REQ-016 rsp_result_o  out  32  response data.
REQ-017 flush_i  in  1  synchronous abort of all queued and in-flight work.
REQ-018 err_o  out  1  sticky FPU timeout flag.

Function
REQ-019 A push occurs iff req_valid_i && req_ready_o; req_ready_o = !full. There is no same-cycle bypass: while full, req_ready_o stays low even in a pop cycle.
REQ-020 The queue is FIFO with wrapping pointers plus a count; full when count == DEPTH, empty when count == 0. Simultaneous push and pop leaves count unchanged.
REQ-021 FSM states are IDLE, ISSUE, WAIT and HOLD; exactly one operation is outstanding at a time.
REQ-022 IDLE: if the queue is non-empty, pop the head, load fpu_op_a_o, fpu_op_b_o and fpu_opcode_o from it, and go to ISSUE. Otherwise stay in IDLE.
REQ-023 ISSUE: fpu_enable_o = 1 for exactly this one cycle; clear the wait counter; go to WAIT.
REQ-024 WAIT: the counter increments each cycle.
  - On fpu_valid_i, capture fpu_result_i into rsp_result_o and go to HOLD.
  - If the counter reaches 4*LATENCY without fpu_valid_i, set err_o and go to IDLE with no response.
REQ-025 HOLD: rsp_valid_o = 1. On rsp_ready_i, go to IDLE. rsp_result_o is stable while rsp_valid_o is high.
REQ-026 fpu_valid_i is ignored outside WAIT.
REQ-027 fpu_op_*_o and fpu_opcode_o hold their values from the pop until the next pop.
REQ-028 Latency: with an empty queue and FSM in IDLE, a request accepted at edge t produces:
  - fpu_enable_o high in cycle t+1;
  - rsp_valid_o high from cycle t+2+LATENCY, given an FPU returning fpu_valid_i in cycle t+1+LATENCY.
REQ-029 flush_i has priority over all other events:
  - empty the queue, FSM to IDLE, rsp_valid_o = 0, counter = 0, err_o = 0;
  - a push requested in the same cycle is dropped.
REQ-030 Back-pressure: while in HOLD the queue keeps accepting requests until full.

Reset
REQ-031 On Reset low, asynchronously:
  - FSM = IDLE, queue empty, counter = 0;
  - fpu_enable_o = 0, rsp_valid_o = 0, err_o = 0;
  - rsp_result_o, fpu_op_a_o, fpu_op_b_o = 0; fpu_opcode_o = 0.
REQ-032 Reset asserted mid-operation discards all queued and in-flight work. No response is produced after reset release.

Structure
REQ-033 Package fpu_issue_pkg holds:
  - the FSM state enum;
  - DATA_W = 32 and OPCODE_W = 6;
  - the default LATENCY.
REQ-034 Sub-module fpu_req_fifo (parameter DEPTH, width 70 bits = two 32-bit operands plus 6-bit opcode, push/pop/full/empty/flush) is instantiated once.

Verification
REQ-035 Single op: a = 0x3F800000, b = 0x40000000, opcode 0x00; the stub FPU returns 0x40400000 LATENCY cycles after enable. Required: fpu_enable_o at t+1, rsp_valid_o at t+4, rsp_result_o = 0x40400000.
REQ-036 Back-pressure: rsp_ready_i = 0 and 6 requests are offered back-to-back. Required: the first op reaches HOLD, 4 more are queued, and req_ready_o = 0 for the 6th. Releasing rsp_ready_i then drains results in order.
REQ-037 Timeout: the stub never asserts fpu_valid_i. Required: err_o rises 8 cycles after the WAIT entry, the FSM returns to IDLE, there is no rsp_valid_o, and the next queued op issues.
REQ-038 Flush in WAIT with 2 entries queued, and a late fpu_valid_i one cycle later. Required: rsp_valid_o stays 0, the queue is empty, and req_ready_o = 1 the next cycle.
REQ-039 Reset pulse while in HOLD with 3 entries queued. Required: all outputs are at their reset values immediately, and no response appears after release.
REQ-040 Wrap-around: 10 ops streamed with rsp_ready_i = 1 and result = a xor b. Required: all 10 responses are correct and in order.
